// File: rtl/ibex_rf_ckpt_pkg.sv
// rtl/ibex_rf_ckpt_pkg.sv - shared types and helpers for the checkpointing register file
package ibex_rf_ckpt_pkg;

    typedef enum logic [1:0] {
        RF_IDLE    = 2'd0,
        RF_RESTORE = 2'd1,
        RF_DONE    = 2'd2
    } rf_restore_e;

    localparam int unsigned MaxReadPorts  = 3;
    localparam int unsigned MaxWritePorts = 2;

    // Callers zero-extend to 64 bits; zero padding leaves parity unchanged.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ibex_rf_restore_fsm.sv
// rtl/ibex_rf_restore_fsm.sv - restore sequencer: state, lane-group counter, busy/done
module ibex_rf_restore_fsm
    import ibex_rf_ckpt_pkg::*;
#(
    parameter int unsigned NumGroups = 8,
    parameter int unsigned CntWidth  = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                restore_i,
    output logic                idle_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                copy_en_o,
    output logic [CntWidth-1:0] group_o
);

    rf_restore_e         state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idle_o    = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        copy_en_o = 1'b0;
        case (state_q)
            RF_IDLE: begin
                idle_o = 1'b1;
                if (restore_i) begin
                    state_d = RF_RESTORE;
                    cnt_d   = '0;
                end
            end
            RF_RESTORE: begin
                busy_o    = 1'b1;
                copy_en_o = 1'b1;
                if (cnt_q == CntWidth'(NumGroups - 1)) begin
                    state_d = RF_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            RF_DONE: begin
                done_o  = 1'b1;
                state_d = RF_IDLE;
            end
            default: state_d = RF_IDLE;
        endcase
    end

    assign group_o = cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/ibex_register_file_ckpt.sv
// rtl/ibex_register_file_ckpt.sv - FF register file with snapshot/restore; IBEX_RF_PARITY_EN adds parity
module ibex_register_file_ckpt
    import ibex_rf_ckpt_pkg::*;
#(
    parameter bit          RV32E         = 1'b0,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned NumReadPorts  = 2,
    parameter int unsigned NumWritePorts = 1,
    parameter int unsigned RestoreLanes  = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NumReadPorts-1:0][4:0]           raddr_i,
    output logic [NumReadPorts-1:0][DataWidth-1:0] rdata_o,
    input  logic [NumWritePorts-1:0][4:0]          waddr_i,
    input  logic [NumWritePorts-1:0][DataWidth-1:0] wdata_i,
    input  logic [NumWritePorts-1:0]               we_i,
    input  logic                                   ckpt_i,
    input  logic                                   restore_i,
    output logic                                   busy_o,
    output logic                                   restore_done_o,
    output logic                                   err_o
);

    localparam int unsigned AddrWidth = RV32E ? 4 : 5;
    localparam int unsigned NumWords  = 2 ** AddrWidth;
    localparam int unsigned NumGroups = NumWords / RestoreLanes;
    localparam int unsigned CntWidth  = (NumGroups > 1) ? $clog2(NumGroups) : 1;
`ifdef IBEX_RF_PARITY_EN
    localparam int unsigned StoreWidth = DataWidth + 1;
`else
    localparam int unsigned StoreWidth = DataWidth;
`endif

    typedef logic [StoreWidth-1:0] word_t;

    word_t live_q [NumWords];
    word_t live_d [NumWords];
    word_t snap_q [NumWords];
    word_t snap_d [NumWords];

    logic                idle, copy_en, ckpt_en;
    logic [CntWidth-1:0] group;

    ibex_rf_restore_fsm #(
        .NumGroups (NumGroups),
        .CntWidth  (CntWidth)
    ) u_restore_fsm (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .restore_i (restore_i),
        .idle_o    (idle),
        .busy_o    (busy_o),
        .done_o    (restore_done_o),
        .copy_en_o (copy_en),
        .group_o   (group)
    );

    function automatic logic addr_ok(input logic [4:0] a);
        return (a != 5'd0) && !(RV32E && a[4]);
    endfunction

    function automatic word_t encode(input logic [DataWidth-1:0] d);
`ifdef IBEX_RF_PARITY_EN
        return {even_parity(64'(d)), d};
`else
        return d;
`endif
    endfunction

    // Restore copies take priority; otherwise writes apply in port order so port 1 wins.
    always_comb begin
        for (int i = 0; i < NumWords; i++) begin
            live_d[i] = live_q[i];
            if (copy_en && (CntWidth'(i / RestoreLanes) == group)) begin
                live_d[i] = snap_q[i];
            end
        end
        if (!copy_en && !busy_o) begin
            for (int k = 0; k < NumWritePorts; k++) begin
                if (we_i[k] && addr_ok(waddr_i[k])) begin
                    live_d[waddr_i[k][AddrWidth-1:0]] = encode(wdata_i[k]);
                end
            end
        end
    end

    // Snapshot captures next-state values so same-cycle writes are included.
    assign ckpt_en = idle && ckpt_i && !restore_i;

    always_comb begin
        for (int i = 0; i < NumWords; i++) begin
            snap_d[i] = ckpt_en ? live_d[i] : snap_q[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumWords; i++) begin
                live_q[i] <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumWords; i++) begin
                live_q[i] <= live_d[i];
                snap_q[i] <= snap_d[i];
            end
        end
    end

`ifdef IBEX_RF_PARITY_EN
    logic par_err;
    logic err_q, err_d;
`endif

    always_comb begin
`ifdef IBEX_RF_PARITY_EN
        par_err = 1'b0;
`endif
        for (int p = 0; p < NumReadPorts; p++) begin
            rdata_o[p] = '0;
            if (addr_ok(raddr_i[p])) begin
                rdata_o[p] = live_q[raddr_i[p][AddrWidth-1:0]][DataWidth-1:0];
`ifdef IBEX_RF_PARITY_EN
                par_err = par_err | (^live_q[raddr_i[p][AddrWidth-1:0]]);
`endif
            end
        end
    end

`ifdef IBEX_RF_PARITY_EN
    assign err_d = err_q | par_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
